fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter START_ADDR, default 12'h200, is the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mem_read  output  1  read request to memory.
REQ-005 mem_read_addr  output  12  byte address of the read request.
REQ-006 mem_read_data  input  8  memory data, valid the cycle after a request.
REQ-007 op_valid  output  1  opcode and op_pc are valid.
REQ-008 op_ready  input  1  consumer accepts the opcode.
REQ-009 opcode  output  16  fetched instruction, big-endian: {byte[pc], byte[pc+1]}.
REQ-010 op_pc  output  12  address of the opcode's high byte.
REQ-011 pc_load  input  1  redirect request (jump/call/return/skip from the executor).
REQ-012 pc_load_addr  input  12  new PC; used when pc_load=1.

Function
REQ-013 The memory contract SHALL be: memory samples mem_read/mem_read_addr at a rising edge; mem_read_data holds that byte throughout the following cycle. The fetch unit SHALL capture the byte in that cycle only and SHALL NOT rely on the data holding longer.
REQ-014 FSM states SHALL be FETCH_HI, FETCH_LO, CAPTURE and VALID.
REQ-015 FETCH_HI: mem_read=1, mem_read_addr=pc; the next state is FETCH_LO.
REQ-016 FETCH_LO: hi_byte <= mem_read_data; mem_read=1, mem_read_addr=pc+1 mod 4096; the next state is CAPTURE.
REQ-017 CAPTURE: mem_read=0; opcode <= {hi_byte, mem_read_data}; op_pc <= pc; the next state is VALID.
REQ-018 VALID: op_valid=1, mem_read=0; opcode and op_pc SHALL hold stable until the handshake.
REQ-019 A handshake occurs when op_valid and op_ready are both 1 at a rising edge; pc <= pc+2 mod 4096; the next state is FETCH_HI.
REQ-020 op_valid SHALL be 1 only in VALID; op_ready SHALL be ignored in all other states.
REQ-021 Latency SHALL be exactly 3 cycles from the FETCH_HI cycle to the first op_valid cycle. With op_ready held at 1, throughput SHALL be one opcode every 4 cycles.
REQ-022 Address arithmetic SHALL be 12-bit with wrap-around: pc=12'hFFF fetches its high byte from 12'hFFF and its low byte from 12'h000; pc=12'hFFE advances to 12'h000.
REQ-023 Odd PC values SHALL be legal and fetched unaligned, with no error.
REQ-024 pc_load=1 in any state SHALL set pc <= pc_load_addr, discard any in-flight byte, and force the next state to FETCH_HI. op_valid SHALL be 0 from the next cycle.
REQ-025 pc_load with a simultaneous handshake: the transfer counts as completed; pc takes pc_load_addr, not pc+2.
REQ-026 pc_load in VALID without op_ready: the held opcode is dropped and never transferred.
REQ-027 mem_read SHALL be 1 only in FETCH_HI and FETCH_LO; the fetch unit SHALL never write memory.

Reset
REQ-028 rst_n low SHALL immediately set: state=FETCH_HI, pc=START_ADDR, hi_byte=0, opcode=16'h0000, op_pc=START_ADDR, op_valid=0.
REQ-029 Reset asserted mid-fetch SHALL abandon the fetch. After release, the first read SHALL be at START_ADDR.
REQ-030 Reads issued while in reset SHALL be harmless, since memory reads have no side effects.

Structure
REQ-031 The shared package SHALL hold ADDR_W=12, the default program start 12'h200, and the FSM state encoding.
REQ-032 The block SHALL be a single module; no sub-module is required.

Verification
REQ-033 Memory model preloaded 0x200=8'h12, 0x201=8'h34; reset release with op_ready=1 -> op_valid in cycle 3 after release; opcode=16'h1234, op_pc=12'h200.
REQ-034 Bytes 0x200..0x207 = 00 E0 A2 2A 60 0C 61 08 with op_ready=1 -> opcodes 00E0, A22A, 600C, 6108 at 4-cycle spacing; op_pc values 200, 202, 204, 206.
REQ-035 op_ready=0 for 10 cycles in VALID -> opcode and op_valid held stable and no mem_read; op_ready=1 -> the next fetch starts at pc+2.
REQ-036 pc_load=1 with pc_load_addr=12'h300 during FETCH_LO -> no opcode from the old pc; next op_valid carries {mem[300], mem[301]} with op_pc=12'h300.
REQ-037 pc_load_addr=12'hFFF, mem[FFF]=8'hAB, mem[000]=8'hCD -> opcode=16'hABCD. After the handshake, the next fetch is at 12'h001.
REQ-038 rst_n pulsed low during CAPTURE -> op_valid=0 immediately; after release, the first fetch is from START_ADDR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_unit_pkg;

    localparam int ADDR_W = 12;

    // Program start address loaded by reset unless overridden.
    localparam logic [ADDR_W-1:0] DEFAULT_START_ADDR = 12'h200;

    // Byte-fetch sequencing: two reads, one capture, then hold for the consumer.
    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        CAPTURE  = 2'd2,
        VALID    = 2'd3
    } fetch_state_e;

    // Address increment with natural wrap at the top of the 4 KiB space.
    function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] n);
        return a + n;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetches 16-bit big-endian opcodes one byte at a time from an 8-bit memory.
// Latency: op_valid 3 cycles after the FETCH_HI cycle; one opcode per 4 cycles at full rate.
// Backpressure: holds opcode/op_pc with op_valid until op_ready; pc_load redirects at any time.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = DEFAULT_START_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [7:0]        mem_read_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [15:0]       opcode,
    output logic [ADDR_W-1:0] op_pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [15:0]       opcode_q, opcode_d;
    logic [ADDR_W-1:0] op_pc_q, op_pc_d;
    logic              op_valid_q, op_valid_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] mem_read_addr_q, mem_read_addr_d;

    // Next-state, datapath capture and registered-output decode of the next state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hi_byte_d = hi_byte_q;
        opcode_d  = opcode_q;
        op_pc_d   = op_pc_q;

        unique case (state_q)
            FETCH_HI: state_d = FETCH_LO;
            FETCH_LO: begin
                // Byte for pc is only on the bus this cycle.
                hi_byte_d = mem_read_data;
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                opcode_d = {hi_byte_q, mem_read_data};
                op_pc_d  = pc_q;
                state_d  = VALID;
            end
            VALID: begin
                if (op_ready) begin
                    pc_d    = addr_add(pc_q, ADDR_W'(2));
                    state_d = FETCH_HI;
                end
            end
            default: state_d = FETCH_HI;
        endcase

        // Redirect overrides everything: in-flight bytes are dropped and the
        // held opcode registers are left untouched (op_valid drops instead).
        if (pc_load) begin
            pc_d      = pc_load_addr;
            state_d   = FETCH_HI;
            hi_byte_d = hi_byte_q;
            opcode_d  = opcode_q;
            op_pc_d   = op_pc_q;
        end

        // Outputs are registered: decode them from where the FSM is going.
        // In FETCH_LO the pc cannot have changed, so pc_d+1 is the low byte.
        op_valid_d      = (state_d == VALID);
        mem_read_d      = (state_d == FETCH_HI) || (state_d == FETCH_LO);
        mem_read_addr_d = (state_d == FETCH_LO) ? addr_add(pc_d, ADDR_W'(1)) : pc_d;
    end

    // State and output registers; reset starts a fresh fetch at START_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= FETCH_HI;
            pc_q            <= START_ADDR;
            hi_byte_q       <= 8'h00;
            opcode_q        <= 16'h0000;
            op_pc_q         <= START_ADDR;
            op_valid_q      <= 1'b0;
            mem_read_q      <= 1'b1;
            mem_read_addr_q <= START_ADDR;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            hi_byte_q       <= hi_byte_d;
            opcode_q        <= opcode_d;
            op_pc_q         <= op_pc_d;
            op_valid_q      <= op_valid_d;
            mem_read_q      <= mem_read_d;
            mem_read_addr_q <= mem_read_addr_d;
        end
    end

    assign mem_read      = mem_read_q;
    assign mem_read_addr = mem_read_addr_q;
    assign op_valid      = op_valid_q;
    assign opcode        = opcode_q;
    assign op_pc         = op_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: op_ready and pc_load driven by the bench.
module tb_fetch_unit;

    localparam logic [11:0] START = 12'h200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read;
    logic [11:0] mem_read_addr;
    logic [7:0]  mem_read_data = 8'h00;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [15:0] opcode;
    logic [11:0] op_pc;
    logic        pc_load = 1'b0;
    logic [11:0] pc_load_addr = 12'h000;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [7:0] mem [0:4095];

    // Reference model: pc of the opcode being fetched, cycles until it is
    // presented (3 = first read cycle, 0 = presented), and the presented value.
    logic [11:0] m_pc;
    int          m_wait;
    logic [15:0] m_op;
    logic [11:0] m_oppc;

    logic [15:0] exp034 [4] = '{16'h00E0, 16'hA22A, 16'h600C, 16'h6108};

    fetch_unit #(.START_ADDR(START)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .opcode        (opcode),
        .op_pc         (op_pc),
        .pc_load       (pc_load),
        .pc_load_addr  (pc_load_addr)
    );

    always #5 clk = ~clk;

    // Memory: data valid only for the cycle after a read; junk otherwise.
    always @(posedge clk) begin
        if (mem_read) mem_read_data <= mem[mem_read_addr];
        else          mem_read_data <= 8'($urandom);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge: check outputs against the model, drive inputs,
    // advance the model by one cycle, return at the next negedge.
    task automatic step(input logic rdy, input logic ld, input logic [11:0] la);
        logic [11:0] ea;
        ea = (m_wait == 3) ? m_pc : m_pc + 12'd1;
        check_val("op_valid", 32'(op_valid), 32'(m_wait == 0));
        check_val("mem_read", 32'(mem_read), 32'(m_wait >= 2));
        if (m_wait >= 2) check_val("mem_read_addr", 32'(mem_read_addr), 32'(ea));
        check_val("opcode", 32'(opcode), 32'(m_op));
        check_val("op_pc", 32'(op_pc), 32'(m_oppc));
        op_ready     = rdy;
        pc_load      = ld;
        pc_load_addr = la;
        if (ld) begin
            m_pc   = la;
            m_wait = 3;
        end else if (m_wait == 0) begin
            if (rdy) begin
                m_pc   = m_pc + 12'd2;
                m_wait = 3;
            end
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_op   = {mem[m_pc], mem[m_pc + 12'd1]};
                m_oppc = m_pc;
            end
        end
        @(posedge clk);
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        op_ready = 1'b0;
        pc_load  = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_op_valid", 32'(op_valid), 32'd0);
        check_val("rst_opcode", 32'(opcode), 32'h0000);
        check_val("rst_op_pc", 32'(op_pc), 32'(START));
        rst_n  = 1'b1;
        m_pc   = START;
        m_wait = 3;
        m_op   = 16'h0000;
        m_oppc = START;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
        mem[12'h300] = 8'h5A; mem[12'h301] = 8'hC3;
        mem[12'hFFF] = 8'hAB; mem[12'h000] = 8'hCD;

        // First opcode after reset release.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 12'h000);
        check_val("t1_valid", 32'(op_valid), 32'd1);
        check_val("t1_opcode", 32'(opcode), 32'h1234);
        check_val("t1_op_pc", 32'(op_pc), 32'h200);

        // Back-to-back stream at 4-cycle spacing.
        mem[12'h200] = 8'h00; mem[12'h201] = 8'hE0;
        mem[12'h202] = 8'hA2; mem[12'h203] = 8'h2A;
        mem[12'h204] = 8'h60; mem[12'h205] = 8'h0C;
        mem[12'h206] = 8'h61; mem[12'h207] = 8'h08;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            repeat (3) step(1'b1, 1'b0, 12'h000);
            check_val("stream_opcode", 32'(opcode), 32'(exp034[k]));
            check_val("stream_op_pc", 32'(op_pc), 32'(START + 12'(2 * k)));
            step(1'b1, 1'b0, 12'h000);
        end

        // Stall in VALID for 10 cycles, then accept.
        repeat (3) step(1'b1, 1'b0, 12'h000);
        repeat (10) step(1'b0, 1'b0, 12'h000);
        check_val("stall_valid", 32'(op_valid), 32'd1);
        check_val("stall_op_pc", 32'(op_pc), 32'h208);
        step(1'b1, 1'b0, 12'h000);
        check_val("stall_next_addr", 32'(mem_read_addr), 32'h20A);

        // Redirect during FETCH_LO.
        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b1, 12'h300);
        check_val("redir_addr", 32'(mem_read_addr), 32'h300);
        repeat (3) step(1'b1, 1'b0, 12'h000);
        check_val("redir_opcode", 32'(opcode), 32'h5AC3);
        check_val("redir_op_pc", 32'(op_pc), 32'h300);
        step(1'b1, 1'b0, 12'h000);

        // Wrap at the top of the address space.
        step(1'b1, 1'b1, 12'hFFF);
        repeat (3) step(1'b1, 1'b0, 12'h000);
        check_val("wrap_opcode", 32'(opcode), 32'hABCD);
        step(1'b1, 1'b0, 12'h000);
        check_val("wrap_next_addr", 32'(mem_read_addr), 32'h001);

        // Reset pulsed during CAPTURE: takes effect without a clock edge.
        step(1'b1, 1'b1, 12'h400);
        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b0, 12'h000);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_op_valid", 32'(op_valid), 32'd0);
        check_val("async_opcode", 32'(opcode), 32'h0000);
        check_val("async_op_pc", 32'(op_pc), 32'(START));
        @(negedge clk);
        do_reset();
        check_val("post_rst_addr", 32'(mem_read_addr), 32'(START));
        repeat (4) step(1'b1, 1'b0, 12'h000);

        // Randomized traffic against the model on fresh memory contents.
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic       r;
            logic       l;
            logic [11:0] a;
            r = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 3) == 0) ? 12'hFFF - 12'($urandom_range(0, 2)) : 12'($urandom);
            step(r, l, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end

endmodule
